// File: rtl/prog_loader.sv
// prog_loader: boot loader that streams a length-prefixed, little-endian program image into
// instruction memory and holds the core in reset until the whole image is written.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} state_t;
    localparam logic [31:0] cap = 32'(2 ** ADDR_W);

    state_t            state, state_nx;
    logic [7:0]        len_lo;
    logic [15:0]       len, len_in;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       lanes;
    logic              xfer;

    assign len_in   = {rx_data, len_lo};
    assign rx_ready = state inside {LEN_LO, LEN_HI, DATA};
    assign busy     = rx_ready || state == WRITE;
    assign xfer     = rx_valid && rx_ready;
    assign imem_we  = state == WRITE;
    assign done     = state == DONE;
    assign err      = state == ERROR;
    assign core_rst = state != DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: state_nx = start ? LEN_LO : state;
            LEN_LO:            state_nx = xfer ? LEN_HI : state;
            LEN_HI:            if (xfer) state_nx = len_in == 16'd0 ? DONE : 32'(len_in) > cap ? ERROR : DATA;
            DATA:              state_nx = xfer && byte_cnt == 2'd3 ? WRITE : state;
            WRITE:             state_nx = 32'(word_idx) + 32'd1 == 32'(len) ? DONE : DATA;
            default:           state_nx = IDLE;
        endcase
    end

    // The first three bytes wait in lanes so imem_wdata only changes when a full word is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo     <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            lanes      <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (state == LEN_LO && xfer) len_lo <= rx_data;
            if (state == LEN_HI && xfer) begin
                len      <= len_in;
                byte_cnt <= '0;
                word_idx <= '0;
            end
            if (state == DATA && xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_wdata <= {rx_data, lanes};
                    imem_addr  <= 32'({word_idx, 2'b00});
                end else begin
                    lanes[{byte_cnt, 3'b000} +: 8] <= rx_data;
                end
            end
            if (state == WRITE) word_idx <= word_idx + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven, directed and randomized checks of prog_loader against a
// word-list model of the boot image.
module tb_prog_loader;
    logic        clk = 0, rst = 1, start = 0, rx_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready, imem_we, core_rst, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;

    int total = 0, bad = 0, cyc = 0, hs_cyc = -1, we_ready = 0;
    logic [31:0] wq_a[$], wq_d[$];

    prog_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wq_a.push_back(imem_addr);
            wq_d.push_back(imem_wdata);
            if (rx_ready) we_ready <= we_ready + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit spur);
        int n = 0;
        rx_data  = b;
        rx_valid = 1;
        start    = spur;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            rx_valid = 0;
            start    = 0;
            return;
        end
        if (hs_cyc < 0) hs_cyc = cyc;
        @(negedge clk);
        rx_valid = 0;
        start    = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit rnd);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 2)) : gap, rnd && $urandom_range(0, 3) == 0);
    endtask

    task automatic begin_load();
        wq_a.delete();
        wq_d.delete();
        hs_cyc = -1;
        start  = 1;
        @(negedge clk);
        start  = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_status(input string nm, input logic e_err, input logic e_done);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, e_err});
        chk({nm, "_done"}, {31'd0, done}, {31'd0, e_done});
        chk({nm, "_core_rst"}, {31'd0, core_rst}, {31'd0, !e_done});
        chk({nm, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0, w1;
        logic        e_err, e_done;
        int          e_n;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{16'd2,   32'h00500013, 32'h00100093, 1'b0, 1'b1, 2};
        tbl[1] = '{16'd0,   32'h0,        32'h0,        1'b0, 1'b1, 0};
        tbl[2] = '{16'd257, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        tbl[3] = '{16'd1,   32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1};

        @(negedge clk);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 0;
        @(negedge clk);

        // Vector table: images sent back-to-back with rx_valid held high.
        foreach (tbl[r]) begin
            begin_load();
            send_byte(tbl[r].len[7:0], 0, 0);
            chk("tbl_core_rst_lenlo", {31'd0, core_rst}, 32'd1);
            send_byte(tbl[r].len[15:8], 0, 0);
            if (!tbl[r].e_err)
                for (int i = 0; i < int'(tbl[r].len); i++) send_word(i == 0 ? tbl[r].w0 : tbl[r].w1, 0, 0);
            wait_idle();
            chk_status("tbl", tbl[r].e_err, tbl[r].e_done);
            if (tbl[r].e_done) chk("tbl_latency", 32'(cyc - hs_cyc), 32'(2 + 5 * int'(tbl[r].len)));
            chk("tbl_nwrites", 32'(wq_a.size()), 32'(tbl[r].e_n));
            for (int i = 0; i < tbl[r].e_n && i < wq_a.size(); i++) begin
                chk("tbl_addr", wq_a[i], 32'(4 * i));
                chk("tbl_data", wq_d[i], i == 0 ? tbl[r].w0 : tbl[r].w1);
            end
        end

        // Asynchronous reset between clock edges while DONE.
        #2 rst = 1;
        #1;
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_core_rst", {31'd0, core_rst}, 32'd1);
        @(negedge clk);
        rst = 0;

        // rx_valid toggling 1/0, held high across WRITE.
        begin_load();
        send_byte(8'h02, 1, 0);
        send_byte(8'h00, 1, 0);
        send_word(32'h00500013, 1, 0);
        send_word(32'h00100093, 1, 0);
        wait_idle();
        chk_status("tog", 1'b0, 1'b1);
        chk("tog_nwrites", 32'(wq_a.size()), 32'd2);
        if (wq_a.size() == 2) begin
            chk("tog_addr0", wq_a[0], 32'h0);
            chk("tog_data0", wq_d[0], 32'h00500013);
            chk("tog_addr1", wq_a[1], 32'h4);
            chk("tog_data1", wq_d[1], 32'h00100093);
        end

        // Restart from DONE, abort mid-word with an asynchronous reset, then reload.
        begin_load();
        chk("restart_core_rst", {31'd0, core_rst}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        #2 rst = 1;
        #1;
        chk("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
        chk("abort_we_done_err", {29'd0, imem_we, done, err}, 32'd0);
        @(negedge clk);
        rst = 0;
        chk("abort_nwrites", 32'(wq_a.size()), 32'd0);
        begin_load();
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_word(32'hCAFEF00D, 0, 0);
        wait_idle();
        chk_status("reload", 1'b0, 1'b1);
        chk("reload_nwrites", 32'(wq_a.size()), 32'd1);
        if (wq_a.size() == 1) begin
            chk("reload_addr", wq_a[0], 32'h0);
            chk("reload_data", wq_d[0], 32'hCAFEF00D);
        end

        // Randomized images: random gaps, stray start pulses, lengths around the capacity.
        for (int r = 0; r < 30; r++) begin
            logic [15:0] len;
            logic [31:0] ew[$];
            int          kind;
            logic        e_err;
            int          bad_words;
            kind  = int'($urandom_range(0, 9));
            len   = r == 0 ? 16'd256 : r == 1 ? 16'd257 : kind == 0 ? 16'd0 :
                    kind == 1 ? 16'($urandom_range(258, 65535)) : 16'($urandom_range(1, 6));
            e_err = len > 16'd256;
            ew.delete();
            if (!e_err) for (int i = 0; i < int'(len); i++) ew.push_back($urandom);
            begin_load();
            send_byte(len[7:0], int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
            send_byte(len[15:8], int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
            foreach (ew[i]) send_word(ew[i], 0, 1);
            wait_idle();
            chk_status("rnd", e_err, !e_err);
            chk("rnd_nwrites", 32'(wq_a.size()), 32'(ew.size()));
            bad_words = 0;
            for (int i = 0; i < ew.size() && i < wq_a.size(); i++)
                if (wq_a[i] !== 32'(4 * i) || wq_d[i] !== ew[i]) bad_words++;
            chk("rnd_words_wrong", 32'(bad_words), 32'd0);
        end

        chk("we_with_rx_ready", 32'(we_ready), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Upstream boot stage for the single-cycle RISC-V core. It receives a program as a byte stream with a valid/ready handshake and assembles little-endian 32-bit instructions. It writes those instructions word by word into instruction memory through a dedicated write port. It holds the core in reset (core_rst) until the whole image is loaded, then releases the core so the PC starts fetching at address 0.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a new load; ignored while busy=1
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data holds a valid byte
rx_ready  output  1  loader can accept a byte; a byte transfers on a rising edge with rx_valid&&rx_ready
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  32  byte address of the write, word aligned (same addressing as the PC)
imem_wdata  output  32  assembled instruction word
core_rst  output  1  reset to the core; 1 = core held in reset
busy  output  1  load in progress
done  output  1  image loaded, core released
err  output  1  length header exceeds capacity

Behaviour:
- Stream format: len[7:0], len[15:8] (word count N), then 4N bytes. Each word arrives least-significant byte first; byte k lands in imem_wdata[8k+7:8k].
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, core_rst=1.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0.
  - Byte and word counters cleared.
- State machine: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR. All outputs are registered or decoded from state only (Moore).
- rx_ready=1 only in LEN_LO, LEN_HI and DATA. busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- IDLE: core_rst=1. start -> LEN_LO.
- LEN_LO: on transfer, capture len[7:0] -> LEN_HI.
- LEN_HI: on transfer, capture len[15:8], then:
  - len==0 -> DONE.
  - len > 2**ADDR_W -> ERROR.
  - otherwise -> DATA, with byte_cnt=0 and word_idx=0.
- DATA: on each transfer, store the byte at lane byte_cnt and increment byte_cnt (2 bits, wraps). The transfer of the 4th byte -> WRITE.
- WRITE: lasts exactly one cycle.
  - imem_we=1, imem_addr={word_idx,2'b00}, imem_wdata stable.
  - rx_ready=0, so no byte is accepted.
  - word_idx increments. If word_idx+1==len -> DONE, else -> DATA.
- Latency: the write strobe occurs the cycle after the 4th byte's handshake. With rx_valid held high, N words take 2+5N cycles from the first handshake to DONE.
- DONE: done=1, core_rst=0, busy=0, rx_ready=0. State holds until start.
- start in DONE -> LEN_LO. Next cycle core_rst=1 and done=0, so the core is re-held before any new write.
- ERROR: err=1, core_rst=1, rx_ready=0, no writes. start clears err and goes to LEN_LO.
- start in LEN_LO/LEN_HI/DATA/WRITE: ignored, no restart.
- rx_valid with rx_ready=0: no transfer. The byte must stay presented by the source until it is accepted.
- rst during a load:
  - Any partial word is discarded; words already written remain in memory.
  - The loader returns to IDLE with core_rst=1.
- imem_addr width rule: bits [ADDR_W+1:2] carry word_idx; all other bits are 0.
- imem_addr/imem_wdata hold their last values outside WRITE; only imem_we qualifies them.

Test Plan:
1. Assert rst mid-cycle -> outputs change immediately: core_rst=1, rx_ready=0, imem_we=0, done=0, err=0, busy=0.
2. start, then bytes 02 00 13 00 50 00 93 00 10 00 with rx_valid held high -> exactly two imem_we pulses: addr 0x0 data 0x00500013, then addr 0x4 data 0x00100093. done=1 and core_rst=0 the cycle after the second write; total 12 cycles from the first handshake.
3. Same image with rx_valid toggled 1/0 every cycle, and held high through each WRITE cycle -> identical writes and data. rx_ready=0 during WRITE, and no byte is dropped or duplicated.
4. start, bytes 00 00 -> DONE with no imem_we pulse; core_rst falls one cycle after the LEN_HI handshake.
5. ADDR_W=8, header 01 01 (len=257) -> err=1, core_rst=1, rx_ready=0, no writes. A following start clears err and a valid 1-word load (01 00 EF BE AD DE) writes 0xDEADBEEF at addr 0x0.
6. After DONE, start is pulsed and 2 data bytes sent, then rst asserted -> IDLE, core_rst=1, no write issued. A fresh load of 1 word writes its own 4 bytes with no residue from the aborted word.
